data_receiver: RTL

Serial receiver on the single network data wire, the consumer of the serial sender's output. Once armed by the network FSM, it watches the line MSB-first for the syncword, then shifts in the encoded payload and presents it as one parallel word with a one-cycle valid strobe. Its output feeds the decoder and the network FSM.

---
 rtl/NetworkPkg.sv | 16 +
 rtl/sync_detector.sv | 45 ++++
 rtl/data_receiver.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/NetworkPkg.sv
// Shared network constants and the receiver state type.
package NetworkPkg;

    localparam int unsigned ENC_DATA_BITS = 16;
    localparam int unsigned SYNC_BITS     = 8;
    localparam logic [SYNC_BITS-1:0] SYNCWORD = 8'hB5;
    // Syncword plus encoded payload as it appears on the wire.
    localparam int unsigned DATA_PKT_BITS = SYNC_BITS + ENC_DATA_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        RECV = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_detector.sv
// Syncword window: MSB-first shift register, saturating fill count and pattern compare.
// match is combinational on the updated window so the caller can leave HUNT on the very
// edge that samples the last sync bit.
module sync_detector
    import NetworkPkg::*;
#(
    parameter int unsigned               SYNC_W       = SYNC_BITS,
    parameter logic [SYNC_W-1:0]         SYNC_PATTERN = SYNCWORD
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic match
);

    localparam logic [7:0] FILL_MAX = 8'(SYNC_W);

    logic [SYNC_W-1:0] r_win;
    logic [SYNC_W-1:0] w_win_next;
    logic [7:0]        r_fill;
    logic [7:0]        w_fill_next;

    // Next window and fill count as they would be after sampling bit_in.
    always_comb begin
        w_win_next  = {r_win[SYNC_W-2:0], bit_in};
        w_fill_next = (r_fill == FILL_MAX) ? r_fill : r_fill + 8'd1;
    end

    // A match needs a full window of real samples, not leftover reset zeros.
    assign match = en && (w_win_next == SYNC_PATTERN) && (w_fill_next == FILL_MAX);

    // Window and fill count update only while enabled; clear restarts the search.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_win  <= '0;
            r_fill <= 8'd0;
        end else if (en) begin
            r_win  <= w_win_next;
            r_fill <= w_fill_next;
        end
    end

endmodule

// File: rtl/data_receiver.sv
// Serial packet receiver: hunts for the syncword MSB-first, then shifts in DATA_W payload
// bits and presents them as one word with a one-cycle data_valid strobe.
// Optional feature macro: DATA_RECV_SYNC_TIMEOUT_EN enables the HUNT timeout counter and
// the sync_timeout pulse; without it sync_timeout is tied low.
module data_receiver
    import NetworkPkg::*;
#(
    parameter int unsigned       DATA_W       = ENC_DATA_BITS,
    parameter int unsigned       SYNC_W       = SYNC_BITS,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNCWORD,
    parameter int unsigned       SYNC_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              recv_start,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              sync_timeout
);

    // Elaboration-time parameter sanity checks.
    if (SYNC_W < 2 || SYNC_W > 255) begin : g_bad_sync_w
        $error("data_receiver: SYNC_W must be in 2..255");
    end
    if (DATA_W < 1 || DATA_W > 255) begin : g_bad_data_w
        $error("data_receiver: DATA_W must be in 1..255");
    end
    if (SYNC_PATTERN == '0) begin : g_bad_pattern
        $error("data_receiver: SYNC_PATTERN must contain a 1");
    end
    if (SYNC_TIMEOUT < 1 || SYNC_TIMEOUT > 255) begin : g_bad_timeout
        $error("data_receiver: SYNC_TIMEOUT must be in 1..255");
    end

    localparam logic [7:0] BIT_LAST = 8'(DATA_W - 1);

    rx_state_t         r_state;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [7:0]        r_bit_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_busy;
    logic              w_match;
    logic              w_hunt_en;

    // The window only advances while hunting; an arming pulse clears it instead.
    assign w_hunt_en = (r_state == HUNT) && !recv_start;

    sync_detector #(
        .SYNC_W       (SYNC_W),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync_detector (
        .clk    (clk),
        .rst    (rst),
        .clear  (recv_start),
        .en     (w_hunt_en),
        .bit_in (serial_in),
        .match  (w_match)
    );

    // Payload with the current line bit appended; first sampled bit ends up as the MSB.
    always_comb begin
        w_shift_next = DATA_W'({r_shift, serial_in});
    end

`ifdef DATA_RECV_SYNC_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(SYNC_TIMEOUT - 1);

    logic [7:0] r_to_cnt;
    logic       r_sync_timeout;

    // Receiver FSM with HUNT timeout; all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_bit_cnt      <= 8'd0;
            r_to_cnt       <= 8'd0;
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            r_busy         <= 1'b0;
            r_sync_timeout <= 1'b0;
        end else begin
            r_data_valid   <= 1'b0;
            r_sync_timeout <= 1'b0;
            if (recv_start) begin
                // Arming wins over everything, including a final data bit on this edge.
                r_state   <= HUNT;
                r_busy    <= 1'b1;
                r_shift   <= '0;
                r_bit_cnt <= 8'd0;
                r_to_cnt  <= 8'd0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                    end
                    HUNT: begin
                        if (w_match) begin
                            r_state   <= RECV;
                            r_bit_cnt <= 8'd0;
                            r_to_cnt  <= 8'd0;
                        end else if (r_to_cnt == TIMEOUT_LAST) begin
                            r_state        <= IDLE;
                            r_busy         <= 1'b0;
                            r_sync_timeout <= 1'b1;
                            r_to_cnt       <= 8'd0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 8'd1;
                        end
                    end
                    RECV: begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_data_out   <= w_shift_next;
                            r_data_valid <= 1'b1;
                            r_busy       <= 1'b0;
                            r_bit_cnt    <= 8'd0;
                            r_state      <= IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sync_timeout = r_sync_timeout;
`else
    // Receiver FSM without timeout: HUNT persists until a match or a new arming pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= 8'd0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (recv_start) begin
                // Arming wins over everything, including a final data bit on this edge.
                r_state   <= HUNT;
                r_busy    <= 1'b1;
                r_shift   <= '0;
                r_bit_cnt <= 8'd0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                    end
                    HUNT: begin
                        if (w_match) begin
                            r_state   <= RECV;
                            r_bit_cnt <= 8'd0;
                        end
                    end
                    RECV: begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_data_out   <= w_shift_next;
                            r_data_valid <= 1'b1;
                            r_busy       <= 1'b0;
                            r_bit_cnt    <= 8'd0;
                            r_state      <= IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sync_timeout = 1'b0;
`endif

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign busy       = r_busy;

endmodule
